// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and default opcode limit for the ALU arbiter.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    localparam logic [3:0] LAST_OP_DEFAULT = OP_NOR;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU; carry_out is the ADD carry or the SUB borrow, else 0.
module alu
    import alu_pkg::*;
(
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] alu_sel,
    output logic [7:0] alu_out,
    output logic       carry_out
);

    logic [8:0] sum;
    logic [8:0] diff;
    logic [7:0] prod;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};
    assign prod = A * B;

    always_comb begin
        alu_out   = 8'h00;
        carry_out = 1'b0;
        unique case (alu_sel)
            OP_ADD:  begin alu_out = sum[7:0];  carry_out = sum[8];  end
            OP_SUB:  begin alu_out = diff[7:0]; carry_out = diff[8]; end
            OP_MUL:  alu_out = prod;
            // Divide by zero saturates instead of producing X.
            OP_DIV:  alu_out = (B == 8'h00) ? 8'hFF : A / B;
            OP_SHL:  alu_out = {A[6:0], 1'b0};
            OP_SHR:  alu_out = {1'b0, A[7:1]};
            OP_ROL:  alu_out = {A[6:0], A[7]};
            OP_ROR:  alu_out = {A[0], A[7:1]};
            OP_AND:  alu_out = A & B;
            OP_OR:   alu_out = A | B;
            OP_XOR:  alu_out = A ^ B;
            OP_NOR:  alu_out = ~(A | B);
            OP_NAND: alu_out = ~(A & B);
            OP_XNOR: alu_out = ~(A ^ B);
            OP_GT:   alu_out = {7'b0, A > B};
            OP_EQ:   alu_out = {7'b0, A == B};
            default: alu_out = 8'h00;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_valid
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu between NREQ requesters with a registered response channel.
// ALU_ILLEGAL_OP_EN: opcodes above LAST_OP are accepted but flagged via rsp_err.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
`ifdef ALU_ILLEGAL_OP_EN
    ,
    parameter logic [3:0]  LAST_OP = LAST_OP_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    input  logic [4*NREQ-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_result,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic              busy
);

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]     op_a_q, op_b_q;
    logic [3:0]     op_sel_q;
    logic [IDW-1:0] op_id_q;
    logic           rsp_valid_q, rsp_carry_q;
    logic [IDW-1:0] rsp_id_q;
    logic [7:0]     rsp_result_q;
    logic           load_ops, capture, rsp_done;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_valid;
    logic [7:0]      alu_out;
    logic            carry_out;

    logic [7:0] a_arr  [NREQ];
    logic [7:0] b_arr  [NREQ];
    logic [3:0] op_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g]  = req_a[8*g +: 8];
        assign b_arr[g]  = req_b[8*g +: 8];
        assign op_arr[g] = req_op[4*g +: 4];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req         (req_valid),
        .rr_ptr      (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    alu u_alu (
        .A         (op_a_q),
        .B         (op_b_q),
        .alu_sel   (op_sel_q),
        .alu_out   (alu_out),
        .carry_out (carry_out)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        req_ready = '0;
        load_ops  = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    req_ready = grant;
                    load_ops  = 1'b1;
                    rr_ptr_d  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d   = StExec;
                end
            end
            StExec: begin
                capture = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef ALU_ILLEGAL_OP_EN
    logic op_ill_q;
    logic rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_ill_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            if (load_ops) op_ill_q <= (op_arr[grant_idx] > LAST_OP);
            if (capture)  rsp_err_q <= op_ill_q;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sel_q     <= '0;
            op_id_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
        end else begin
            if (load_ops) begin
                op_a_q   <= a_arr[grant_idx];
                op_b_q   <= b_arr[grant_idx];
                op_sel_q <= op_arr[grant_idx];
                op_id_q  <= grant_idx;
            end
            if (capture) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= op_id_q;
`ifdef ALU_ILLEGAL_OP_EN
                rsp_result_q <= op_ill_q ? 8'h00 : alu_out;
                rsp_carry_q  <= op_ill_q ? 1'b0 : carry_out;
`else
                rsp_result_q <= alu_out;
                rsp_carry_q  <= carry_out;
`endif
            end else if (rsp_done) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign busy       = (state_q != StIdle);

endmodule
